key_event_ctrl: RTL

Multi-key front-end controller that serves N raw push-buttons with one shared sample-tick prescaler. It runs a per-key debounce/hold state machine and turns the debounced activity into typed events: press, long-press, auto-repeat and release. Events are arbitrated round-robin into a small FIFO drained through a valid/ready handshake. It sits between the board buttons and the display/mode controller, replacing per-key free-running debounce counters.

---
 rtl/key_evt_pkg.sv | 29 ++
 rtl/key_fsm.sv | 151 +++++++++++++++
 rtl/key_event_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event controller.
// Holds the event type encodings presented on evt_type, the per-key
// debounce/hold state encodings, and a helper that sizes a saturating
// counter to hold the larger of two limits.
package key_evt_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_LONG    = 2'd1,
    EVT_REPEAT  = 2'd2,
    EVT_RELEASE = 2'd3
  } evt_type_t;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_PRESSED     = 3'd2,
    ST_HELD        = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } key_state_t;

  // Bits needed for a counter that must reach max(a, b) without wrapping.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_fsm.sv
// Per-key debounce and hold-timing state machine.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   tick        : one-cycle sample strobe from the shared prescaler
//   sample      : synchronized raw key level (1 = pressed)
//   level       : debounced key level (registered)
//   evt_req     : an event is raised this cycle (combinational, tick cycles only)
//   evt_code    : type of the raised event
//   evt_clash   : a RELEASE and a LONG/REPEAT fell on the same tick; RELEASE wins
module key_fsm
  import key_evt_pkg::*;
#(
  parameter int DEB_TICKS  = 20,
  parameter int LONG_TICKS = 1000,
  parameter int REP_TICKS  = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       sample,
  output logic       level,
  output logic       evt_req,
  output logic [1:0] evt_code,
  output logic       evt_clash
);

  localparam int CW = cnt_width(LONG_TICKS, REP_TICKS);
  localparam int DW = cnt_width(DEB_TICKS, 1);
  localparam logic [CW-1:0] LONG_LIM = CW'(LONG_TICKS);
  localparam logic [CW-1:0] REP_LIM  = CW'(REP_TICKS);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

  key_state_t    state_reg, state_next;
  logic [DW-1:0] dcnt_reg, dcnt_next, dcnt_inc;
  logic [CW-1:0] hcnt_reg, hcnt_next, hcnt_inc;
  logic          held_reg, held_next;
  logic          level_reg, level_next;
  logic          press_evt, rel_evt, hold_evt;
  logic [1:0]    hold_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      dcnt_reg  <= '0;
      hcnt_reg  <= '0;
      held_reg  <= 1'b0;
      level_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      dcnt_reg  <= dcnt_next;
      hcnt_reg  <= hcnt_next;
      held_reg  <= held_next;
      level_reg <= level_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dcnt_next  = dcnt_reg;
    hcnt_next  = hcnt_reg;
    held_next  = held_reg;
    level_next = level_reg;
    press_evt  = 1'b0;
    rel_evt    = 1'b0;
    hold_evt   = 1'b0;
    hold_code  = EVT_LONG;
    dcnt_inc   = (dcnt_reg == '1) ? dcnt_reg : dcnt_reg + 1'b1;
    hcnt_inc   = (hcnt_reg == '1) ? hcnt_reg : hcnt_reg + 1'b1;

    if (tick) begin
      // Hold timing keeps running through a release debounce so a bounce
      // during a long hold does not restart the LONG/REPEAT schedule.
      if (state_reg inside {ST_PRESSED, ST_HELD, ST_DEB_RELEASE}) begin
        hcnt_next = hcnt_inc;
        if (!held_reg && hcnt_inc == LONG_LIM) begin
          hold_evt  = 1'b1;
          hold_code = EVT_LONG;
          held_next = 1'b1;
          hcnt_next = '0;
        end else if (held_reg && hcnt_inc == REP_LIM) begin
          hold_evt  = 1'b1;
          hold_code = EVT_REPEAT;
          hcnt_next = '0;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (sample) begin
            if (DEB_TICKS <= 1) begin
              state_next = ST_PRESSED;
              level_next = 1'b1;
              press_evt  = 1'b1;
              hcnt_next  = '0;
              held_next  = 1'b0;
            end else begin
              state_next = ST_DEB_PRESS;
              dcnt_next  = DEB_ONE;
            end
          end
        end
        ST_DEB_PRESS: begin
          if (!sample) begin
            state_next = ST_IDLE;
          end else if (dcnt_reg == DEB_LAST) begin
            state_next = ST_PRESSED;
            level_next = 1'b1;
            press_evt  = 1'b1;
            hcnt_next  = '0;
            held_next  = 1'b0;
          end else begin
            dcnt_next = dcnt_inc;
          end
        end
        ST_PRESSED, ST_HELD: begin
          if (!sample) begin
            if (DEB_TICKS <= 1) begin
              state_next = ST_IDLE;
              level_next = 1'b0;
              rel_evt    = 1'b1;
            end else begin
              state_next = ST_DEB_RELEASE;
              dcnt_next  = DEB_ONE;
            end
          end else begin
            state_next = held_next ? ST_HELD : ST_PRESSED;
          end
        end
        ST_DEB_RELEASE: begin
          if (sample) begin
            state_next = held_next ? ST_HELD : ST_PRESSED;
          end else if (dcnt_reg == DEB_LAST) begin
            state_next = ST_IDLE;
            level_next = 1'b0;
            rel_evt    = 1'b1;
          end else begin
            dcnt_next = dcnt_inc;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign level     = level_reg;
  assign evt_req   = press_evt | rel_evt | hold_evt;
  assign evt_code  = rel_evt ? EVT_RELEASE : (press_evt ? EVT_PRESS : hold_code);
  assign evt_clash = rel_evt & hold_evt;

endmodule

// File: rtl/key_event_ctrl.sv
// Multi-key front end: shared sample prescaler, per-key debounce/hold FSMs,
// one pending-event slot per key, round-robin arbiter and an event FIFO
// drained through a valid/ready handshake.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   key_in      : raw button levels, 1 = pressed (asynchronous)
//   key_level   : debounced level per key
//   evt_valid   : FIFO head event available
//   evt_ready   : consumer takes the head when evt_valid & evt_ready
//   evt_key     : key index of the head event
//   evt_type    : 0=PRESS 1=LONG 2=REPEAT 3=RELEASE
//   overflow    : sticky, an event was dropped since reset
module key_event_ctrl
  import key_evt_pkg::*;
#(
  parameter int N_KEYS     = 4,
  parameter int TICK_DIV   = 100_000,
  parameter int DEB_TICKS  = 20,
  parameter int LONG_TICKS = 1000,
  parameter int REP_TICKS  = 200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_KEYS-1:0]         key_in,
  output logic [N_KEYS-1:0]         key_level,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(N_KEYS)-1:0] evt_key,
  output logic [1:0]                evt_type,
  output logic                      overflow
);

  localparam int KW   = $clog2(N_KEYS);
  localparam int PW   = $clog2(TICK_DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  // ---------------- synchronizer and prescaler ----------------
  logic [N_KEYS-1:0] sync1_reg, sync2_reg;
  logic [PW-1:0]     presc_reg;
  logic              tick;

  assign tick = (presc_reg == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      presc_reg <= '0;
    end else begin
      sync1_reg <= key_in;
      sync2_reg <= sync1_reg;
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
    end
  end

  // ---------------- per-key FSMs and pending slots ----------------
  logic [N_KEYS-1:0] evt_req, evt_clash, granted, drop;
  logic [1:0]        evt_code [N_KEYS];
  logic              slot_valid_reg [N_KEYS];
  logic [1:0]        slot_type_reg [N_KEYS];
  logic              gnt_valid;
  logic [KW-1:0]     gnt_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      key_fsm #(
        .DEB_TICKS (DEB_TICKS),
        .LONG_TICKS(LONG_TICKS),
        .REP_TICKS (REP_TICKS)
      ) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .sample   (sync2_reg[gi]),
        .level    (key_level[gi]),
        .evt_req  (evt_req[gi]),
        .evt_code (evt_code[gi]),
        .evt_clash(evt_clash[gi])
      );

      assign granted[gi] = gnt_valid && (gnt_idx == KW'(gi));
      // A slot being granted this cycle is free to take a new event.
      assign drop[gi] = (evt_req[gi] && slot_valid_reg[gi] && !granted[gi]) || evt_clash[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_valid_reg[gi] <= 1'b0;
          slot_type_reg[gi]  <= EVT_PRESS;
        end else if (evt_req[gi] && (!slot_valid_reg[gi] || granted[gi])) begin
          slot_valid_reg[gi] <= 1'b1;
          slot_type_reg[gi]  <= evt_code[gi];
        end else if (granted[gi]) begin
          slot_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // ---------------- FIFO state ----------------
  logic [KW+1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNTW-1:0] count_reg;
  logic            full, push, pop, can_push;
  logic [KW+1:0]   head;

  assign full     = (count_reg == CNTW'(FIFO_DEPTH));
  assign pop      = evt_ready && (count_reg != '0);
  assign can_push = !full || pop;
  assign push     = gnt_valid;

  // ---------------- round-robin arbiter ----------------
  logic [KW-1:0] last_gnt_reg;

  always_comb begin
    int j;
    j         = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 1; i <= N_KEYS; i++) begin
      j = int'(last_gnt_reg) + i;
      if (j >= N_KEYS) j = j - N_KEYS;
      if (!gnt_valid && can_push && slot_valid_reg[KW'(j)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = KW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_reg <= KW'(N_KEYS - 1);  // first search starts at key 0
      overflow     <= 1'b0;
    end else begin
      if (gnt_valid) last_gnt_reg <= gnt_idx;
      if (|drop) overflow <= 1'b1;
    end
  end

  // ---------------- FIFO ----------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {gnt_idx, slot_type_reg[gnt_idx]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head outputs are forced to zero while empty so reset shows 0 without
  // having to clear the storage array.
  assign head      = mem[rd_ptr_reg];
  assign evt_valid = (count_reg != '0);
  assign evt_key   = evt_valid ? head[KW+1:2] : '0;
  assign evt_type  = evt_valid ? head[1:0] : 2'd0;

endmodule
